// File: rtl/board_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : board_clear_sequencer
// Purpose  : Owns the single read/write port of the game-board row memory.
//            The VGA renderer gets absolute priority for reads. An internal
//            sequencer scans the board bottom-up on request. It drops full
//            rows and compacts the remaining rows downward, then zero-fills
//            the vacated top rows. Finally it adds the line-clear points to a
//            3-digit BCD score.
// Ports    : clk, reset_n (async, active low)
//            start / busy / done / lines_cleared : pass control and status
//            score_clr, score_1..3               : BCD score (ones..hundreds)
//            rnd_req/rnd_addr/rnd_gnt/rnd_valid  : renderer read channel
//            mem_addr/mem_we/mem_wdata/mem_rdata : board memory port
//                                                  (1-cycle read latency)
// Revision : 1.0 - initial release
// ============================================================================
module board_clear_sequencer #(
    parameter int BLOCKS_W = 10,
    parameter int BLOCKS_H = 20,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [4:0]          lines_cleared,
    input  logic                score_clr,
    output logic [3:0]          score_1,
    output logic [3:0]          score_2,
    output logic [3:0]          score_3,
    input  logic                rnd_req,
    input  logic [ADDR_W-1:0]   rnd_addr,
    output logic                rnd_gnt,
    output logic                rnd_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [BLOCKS_W-1:0] mem_wdata,
    input  logic [BLOCKS_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] c_TOP = ADDR_W'(BLOCKS_H - 1);
    localparam logic [ADDR_W-1:0] c_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_CAP   = 3'd2,
        S_WR    = 3'd3,
        S_FILL  = 3'd4,
        S_SCORE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_rp;
    logic [ADDR_W-1:0]   r_wp;
    logic [BLOCKS_W-1:0] r_row;
    logic [4:0]          r_cnt;
    logic [4:0]          r_lines;
    logic [3:0]          r_score1;
    logic [3:0]          r_score2;
    logic [3:0]          r_score3;
    logic                r_rnd_valid;

    logic                w_row_full;
    logic [4:0]          w_cnt_cap;
    logic                w_fill_wr;
    logic [3:0]          w_points;
    logic [4:0]          w_sum1;
    logic                w_c1;
    logic                w_c2;
    logic [3:0]          w_d1;
    logic [3:0]          w_d2;
    logic [3:0]          w_d3;

    // Row count including the row being captured, so the last-row decision
    // in CAP can skip FILL entirely when nothing was cleared.
    assign w_row_full = &mem_rdata;
    assign w_cnt_cap  = r_cnt + {4'd0, w_row_full};
    assign w_fill_wr  = (r_state == S_FILL) && (r_cnt != 5'd0);

    // Memory port mux: the renderer always wins, the sequencer simply holds.
    assign rnd_gnt   = rnd_req;
    assign mem_we    = !rnd_req && ((r_state == S_WR) || w_fill_wr);
    assign mem_wdata = (!rnd_req && (r_state == S_WR)) ? r_row : '0;

    always_comb begin
        mem_addr = '0;
        if (rnd_req) begin
            mem_addr = rnd_addr;
        end else if (r_state == S_RD) begin
            mem_addr = r_rp;
        end else if ((r_state == S_WR) || w_fill_wr) begin
            mem_addr = r_wp;
        end
    end

    // Status outputs are pure decodes of the state register.
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign lines_cleared = r_lines;
    assign rnd_valid     = r_rnd_valid;
    assign score_1       = r_score1;
    assign score_2       = r_score2;
    assign score_3       = r_score3;

    // Points table and single-step BCD add (max 9 + 8 = 17 on the ones digit).
    always_comb begin
        case (r_cnt)
            5'd0:    w_points = 4'd0;
            5'd1:    w_points = 4'd1;
            5'd2:    w_points = 4'd3;
            5'd3:    w_points = 4'd5;
            default: w_points = 4'd8;
        endcase
    end

    assign w_sum1 = {1'b0, r_score1} + {1'b0, w_points};
    assign w_c1   = (w_sum1 > 5'd9);
    assign w_d1   = w_c1 ? 4'(w_sum1 - 5'd10) : w_sum1[3:0];
    assign w_c2   = w_c1 && (r_score2 == 4'd9);
    assign w_d2   = w_c2 ? 4'd0 : (r_score2 + {3'd0, w_c1});
    assign w_d3   = (w_c2 && (r_score3 == 4'd9)) ? 4'd0 : (r_score3 + {3'd0, w_c2});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_rp        <= '0;
            r_wp        <= '0;
            r_row       <= '0;
            r_cnt       <= '0;
            r_lines     <= '0;
            r_rnd_valid <= 1'b0;
        end else begin
            r_rnd_valid <= rnd_req;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rp    <= c_TOP;
                        r_wp    <= c_TOP;
                        r_cnt   <= '0;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (!rnd_req) begin
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    r_row <= mem_rdata;
                    if (w_row_full || (r_wp == r_rp)) begin
                        // Full row is dropped; a non-full row already in
                        // place only advances the write pointer.
                        if (w_row_full) begin
                            r_cnt <= w_cnt_cap;
                        end else begin
                            r_wp <= r_wp - c_ONE;
                        end
                        if (r_rp == '0) begin
                            r_state <= (w_cnt_cap != 5'd0) ? S_FILL : S_SCORE;
                        end else begin
                            r_rp    <= r_rp - c_ONE;
                            r_state <= S_RD;
                        end
                    end else begin
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    if (!rnd_req) begin
                        r_wp <= r_wp - c_ONE;
                        if (r_rp == '0) begin
                            r_state <= (r_cnt != 5'd0) ? S_FILL : S_SCORE;
                        end else begin
                            r_rp    <= r_rp - c_ONE;
                            r_state <= S_RD;
                        end
                    end
                end
                S_FILL: begin
                    if (r_cnt == 5'd0) begin
                        r_state <= S_SCORE;
                    end else if (!rnd_req) begin
                        if (r_wp == '0) begin
                            r_state <= S_SCORE;
                        end else begin
                            r_wp <= r_wp - c_ONE;
                        end
                    end
                end
                S_SCORE: begin
                    r_lines <= r_cnt;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Score clear wins over a coincident update and works in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_score1 <= '0;
            r_score2 <= '0;
            r_score3 <= '0;
        end else if (score_clr) begin
            r_score1 <= '0;
            r_score2 <= '0;
            r_score3 <= '0;
        end else if (r_state == S_SCORE) begin
            r_score1 <= w_d1;
            r_score2 <= w_d2;
            r_score3 <= w_d3;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_clear_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_clear_sequencer
// Purpose  : Self-checking bench for board_clear_sequencer. It holds a
//            behavioural board memory and a reference model working on whole
//            rows and decimal score arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_clear_sequencer;

    localparam int W  = 10;
    localparam int H  = 20;
    localparam int AW = 5;
    localparam logic [W-1:0] c_FULL = '1;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic          score_clr = 1'b0;
    logic          rnd_req   = 1'b0;
    logic [AW-1:0] rnd_addr  = '0;
    logic          busy;
    logic          done;
    logic [4:0]    lines_cleared;
    logic [3:0]    score_1;
    logic [3:0]    score_2;
    logic [3:0]    score_3;
    logic          rnd_gnt;
    logic          rnd_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;

    logic          ld_en   = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [W-1:0]  ld_data = '0;
    logic [W-1:0]  mem [0:31];
    int            wr_count = 0;

    int checks      = 0;
    int failures    = 0;
    int model_score = 0;

    logic [W-1:0] snap [0:H-1];
    logic [W-1:0] expb [0:H-1];
    int exp_cnt;
    int exp_m;

    board_clear_sequencer #(.BLOCKS_W(W), .BLOCKS_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .score_clr(score_clr),
        .score_1(score_1), .score_2(score_2), .score_3(score_3),
        .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_gnt(rnd_gnt),
        .rnd_valid(rnd_valid), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Board memory: registered read, write-enable port, plus a bench load path.
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
        mem_rdata <= mem[mem_addr];
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic int points(input int n);
        if (n == 0) return 0;
        if (n == 1) return 1;
        if (n == 2) return 3;
        if (n == 3) return 5;
        return 8;
    endfunction

    function automatic logic [11:0] digits(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int board_errs();
        int e = 0;
        for (int r = 0; r < H; r++) if (mem[r] !== expb[r]) e++;
        return e;
    endfunction

    // Reference: drop full rows, stack the survivors at the bottom in order.
    task automatic compute_model();
        int k = H - 1;
        bit seen_full = 1'b0;
        exp_cnt = 0;
        exp_m   = 0;
        for (int i = 0; i < H; i++) expb[i] = '0;
        for (int r = H - 1; r >= 0; r--) begin
            if (snap[r] == c_FULL) begin
                exp_cnt++;
                seen_full = 1'b1;
            end else begin
                expb[k] = snap[r];
                k--;
                if (seen_full) exp_m++;
            end
        end
    endtask

    task automatic make_board(input int nfull);
        int placed = 0;
        int r;
        for (int i = 0; i < H; i++) begin
            snap[i] = W'($urandom_range(0, 1022));
            if ($urandom_range(0, 3) == 0) snap[i] = '0;
        end
        while (placed < nfull) begin
            r = $urandom_range(0, H - 1);
            if (snap[r] != c_FULL) begin
                snap[r] = c_FULL;
                placed++;
            end
        end
    endtask

    task automatic load_board();
        for (int r = 0; r < H; r++) begin
            ld_en   = 1'b1;
            ld_addr = AW'(r);
            ld_data = snap[r];
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
    endtask

    // Pulses start and follows the pass cycle by cycle; optional renderer
    // contention window, score clear cycle and asynchronous reset abort.
    task automatic run_pass(input int stall_at, input int stall_len, input int clr_at,
                            input int rst_at, output int nbusy, output int ndone,
                            output bit last_done);
        int cyc = 0;
        bit prev_req = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        ndone = 0;
        last_done = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (busy === 1'b1 && cyc < 3000) begin
            cyc++;
            if (cyc == rst_at) begin
                reset_n = 1'b0;
                break;
            end
            rnd_req   = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            rnd_addr  = AW'($urandom_range(0, H - 1));
            score_clr = (cyc == clr_at);
            @(negedge clk);
            if (rnd_req) begin
                checks++;
                if (mem_addr !== rnd_addr || mem_we !== 1'b0 || rnd_gnt !== 1'b1) begin
                    failures++;
                    $display("FAIL rnd_priority cyc=%0d: addr=%0d we=%b gnt=%b, required addr=%0d we=0 gnt=1",
                             cyc, mem_addr, mem_we, rnd_gnt, rnd_addr);
                end
            end
            if (prev_req) begin
                checks++;
                if (rnd_valid !== 1'b1 || mem_rdata !== snap[prev_addr]) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d: valid=%b data=%h, required valid=1 data=%h",
                             cyc, rnd_valid, mem_rdata, snap[prev_addr]);
                end
            end
            ndone    += int'(done === 1'b1);
            last_done = (done === 1'b1);
            prev_req  = rnd_req;
            prev_addr = rnd_addr;
            @(posedge clk); #1;
        end
        rnd_req   = 1'b0;
        score_clr = 1'b0;
        nbusy     = cyc;
    endtask

    // Loads snap, runs one pass and compares everything against the model.
    task automatic pass_scenario(input string name, input int stall_at, input int stall_len,
                                 input bit clr_at_score, output int nbusy);
        int ndone, wb, exp_busy, clr_at, errs;
        bit last_done;
        logic [11:0] got;
        load_board();
        compute_model();
        exp_busy = 2 * H + exp_m + exp_cnt + 2 + stall_len;
        clr_at   = clr_at_score ? exp_busy - 1 : 0;
        wb       = wr_count;
        run_pass(stall_at, stall_len, clr_at, 0, nbusy, ndone, last_done);
        model_score = clr_at_score ? 0 : (model_score + points(exp_cnt)) % 1000;

        checks++;
        if (nbusy != exp_busy) begin
            failures++;
            $display("FAIL %s busy_len: got %0d cycles, required %0d", name, nbusy, exp_busy);
        end
        checks++;
        if (ndone != 1 || !last_done) begin
            failures++;
            $display("FAIL %s done_pulse: got %0d pulses last=%b, required 1 in last busy cycle",
                     name, ndone, last_done);
        end
        checks++;
        if (lines_cleared !== 5'(exp_cnt)) begin
            failures++;
            $display("FAIL %s lines_cleared: got %0d, required %0d", name, lines_cleared, exp_cnt);
        end
        got = {score_3, score_2, score_1};
        checks++;
        if (got !== digits(model_score)) begin
            failures++;
            $display("FAIL %s score: got %h, required %h", name, got, digits(model_score));
        end
        checks++;
        if (wr_count - wb != exp_m + exp_cnt) begin
            failures++;
            $display("FAIL %s writes: got %0d, required %0d", name, wr_count - wb, exp_m + exp_cnt);
        end
        errs = board_errs();
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL %s board: %0d rows differ, required 0", name, errs);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rnd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: busy=%b done=%b rnd_valid=%b, required 0 0 0", busy, done, rnd_valid);
        end
        checks++;
        if (lines_cleared !== 5'd0 || {score_3, score_2, score_1} !== 12'h000) begin
            failures++;
            $display("FAIL reset_values: lines=%0d score=%h, required 0 000",
                     lines_cleared, {score_3, score_2, score_1});
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL reset_port: we=%b addr=%0d, required 0 0", mem_we, mem_addr);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        int nb;
        for (int i = 0; i < H; i++) snap[i] = '0;
        pass_scenario("empty", 0, 0, 1'b0, nb);
        checks++;
        if (nb != 42) begin
            failures++;
            $display("FAIL empty_busy42: got %0d, required 42", nb);
        end
    endtask

    task automatic test_one_line();
        int nb;
        for (int i = 0; i < H; i++) snap[i] = '0;
        snap[19] = c_FULL;
        snap[18] = 10'h001;
        pass_scenario("one_line", 0, 0, 1'b0, nb);
        checks++;
        if (nb != 62 || mem[19] !== 10'h001 || {score_3, score_2, score_1} !== 12'h001) begin
            failures++;
            $display("FAIL one_line_abs: busy=%0d row19=%h score=%h, required 62 001 001",
                     nb, mem[19], {score_3, score_2, score_1});
        end
    endtask

    task automatic test_score_clr_idle();
        @(posedge clk); #1;
        score_clr = 1'b1;
        @(posedge clk); #1;
        score_clr = 1'b0;
        model_score = 0;
        checks++;
        if ({score_3, score_2, score_1} !== 12'h000) begin
            failures++;
            $display("FAIL score_clr_idle: got %h, required 000", {score_3, score_2, score_1});
        end
    endtask

    task automatic test_four_lines();
        int nb;
        test_score_clr_idle();
        // 11*8 + 5 + 1 + 1 = 95
        for (int p = 0; p < 14; p++) begin
            make_board(p < 11 ? 4 : (p == 11 ? 3 : 1));
            pass_scenario("build095", 0, 0, 1'b0, nb);
        end
        for (int i = 0; i < H; i++) snap[i] = '0;
        for (int i = 16; i < 20; i++) snap[i] = c_FULL;
        snap[15] = 10'h3F0;
        pass_scenario("four_lines", 0, 0, 1'b0, nb);
        checks++;
        if ({score_3, score_2, score_1} !== 12'h103 || mem[19] !== 10'h3F0 || lines_cleared !== 5'd4) begin
            failures++;
            $display("FAIL four_lines_abs: score=%h row19=%h lines=%0d, required 103 3f0 4",
                     {score_3, score_2, score_1}, mem[19], lines_cleared);
        end
    endtask

    task automatic test_contention();
        int nb;
        make_board(2);
        pass_scenario("contention", 3, 10, 1'b0, nb);
    endtask

    task automatic test_random();
        int nb;
        for (int p = 0; p < 12; p++) begin
            make_board($urandom_range(0, 6));
            pass_scenario("random", 0, 0, 1'b0, nb);
        end
    endtask

    task automatic test_wrap();
        int nb;
        test_score_clr_idle();
        // 124*8 + 3 + 3 = 998
        for (int p = 0; p < 126; p++) begin
            make_board(p < 124 ? $urandom_range(4, 8) : 2);
            pass_scenario("build998", 0, 0, 1'b0, nb);
        end
        make_board(2);
        pass_scenario("wrap", 0, 0, 1'b0, nb);
        checks++;
        if ({score_3, score_2, score_1} !== 12'h001) begin
            failures++;
            $display("FAIL wrap_abs: got %h, required 001", {score_3, score_2, score_1});
        end
    endtask

    task automatic test_clr_at_score();
        int nb;
        make_board(2);
        pass_scenario("clr_at_score", 0, 0, 1'b1, nb);
        checks++;
        if ({score_3, score_2, score_1} !== 12'h000) begin
            failures++;
            $display("FAIL clr_at_score_abs: got %h, required 000", {score_3, score_2, score_1});
        end
    endtask

    task automatic test_reset_mid_fill();
        int nb, nd;
        bit ld;
        make_board(3);
        pass_scenario("pre_reset", 0, 0, 1'b0, nb);
        make_board(4);
        load_board();
        compute_model();
        // FILL occupies cycles 41+M .. 44+M; abort in its second cycle.
        run_pass(0, 0, 0, 2 * H + exp_m + 2, nb, nd, ld);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {score_3, score_2, score_1} !== 12'h000
            || lines_cleared !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid_fill: busy=%b done=%b score=%h lines=%0d, required 0 0 000 0",
                     busy, done, {score_3, score_2, score_1}, lines_cleared);
        end
        model_score = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < H; i++) snap[i] = mem[i];
        pass_scenario("post_reset", 0, 0, 1'b0, nb);
    endtask

    initial begin
        test_reset();
        test_empty();
        test_one_line();
        test_four_lines();
        test_contention();
        test_random();
        test_wrap();
        test_clr_at_score();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_clear_sequencer.md
Name: board_clear_sequencer

Overview:
- Owns the single read/write port of the game-board row memory and shares it between two users: the VGA renderer (reads) and an internal line-clear sequencer.
- On a start pulse from the game FSM, the sequencer scans the board bottom-up and compacts the non-full rows downward. It then zero-fills the vacated top rows and adds the line-clear points to a 3-digit BCD score.
- It sits between the game logic FSM (its CHECK/REMOVE phase), the board memory and the pixel renderer.

Parameters:
- BLOCKS_W, 10, board width in cells (row word width).
- BLOCKS_H, 20, board height in rows.
- ADDR_W, 5, row address width; must satisfy 2^ADDR_W >= BLOCKS_H.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a clear pass; sampled only in IDLE.
- busy  out  1  high while the pass runs (state != IDLE).
- done  out  1  one-cycle pulse marking the end of the pass.
- lines_cleared  out  5  full rows found in the last pass; held until the next start.
- score_clr  in  1  synchronous clear of the score digits.
- score_1  out  4  BCD ones digit.
- score_2  out  4  BCD tens digit.
- score_3  out  4  BCD hundreds digit.
- rnd_req  in  1  renderer read request.
- rnd_addr  in  ADDR_W  renderer row address.
- rnd_gnt  out  1  combinational grant; equals rnd_req.
- rnd_valid  out  1  rnd_req delayed by one cycle; mem_rdata is renderer data when high.
- mem_addr  out  ADDR_W  board memory address.
- mem_we  out  1  board memory write enable.
- mem_wdata  out  BLOCKS_W  board memory write data.
- mem_rdata  in  BLOCKS_W  board memory read data, registered, 1-cycle latency.

Behaviour:
- Reset, asynchronous: state=IDLE, busy=0, done=0, lines_cleared=0, score digits=0, rnd_valid=0, internal pointers=0. A reset mid-pass abandons the pass immediately; the board may be left partially compacted.
- Arbitration: the renderer has absolute priority.
  - When rnd_req=1: mem_addr=rnd_addr, mem_we=0, and the sequencer's port request is stalled (its state holds).
  - Continuous rnd_req stalls the sequencer indefinitely; blanking intervals provide the bandwidth.
  - When the port is idle: mem_we=0, mem_addr=0.
- Internal registers: read pointer rp, write pointer wp, captured row row_q, 5-bit counter cnt.
- State machine:
  - IDLE: on start, rp=wp=BLOCKS_H-1, cnt=0, go to RD. A start while busy is ignored.
  - RD: needs the port. When granted, drive mem_addr=rp and go to CAP.
  - CAP: no port use. Latch row_q=mem_rdata.
    - If &row_q: cnt++, go to NEXT-ROW.
    - Else if wp==rp: wp--, go to NEXT-ROW.
    - Else: go to WR.
  - WR: needs the port. When granted, mem_we=1, mem_addr=wp, mem_wdata=row_q; wp--, go to NEXT-ROW.
  - NEXT-ROW (a decision, not a state): if rp==0 go to FILL; otherwise rp--, go to RD.
  - FILL: if cnt==0, go to SCORE. Otherwise it needs the port; when granted, write zeros at wp. If wp==0 go to SCORE, else wp--. After compaction wp = cnt-1, so exactly cnt rows are zeroed.
  - SCORE: lines_cleared=cnt; add points to the score; go to DONE.
  - DONE: done=1; go to IDLE.
- Points: cnt 0→0, 1→1, 2→3, 3→5, >=4→8.
- BCD add:
  - s = score_1 + points. If s>9, score_1=s-10 and carry into tens; otherwise score_1=s.
  - Tens 9+carry → 0 with carry into hundreds.
  - Hundreds 9+carry → 0; 999 wraps to the low digits of the sum, e.g. 999+1=000.
- score_clr has priority over a coincident SCORE update and is accepted in any state.
- Latency without contention: start seen in cycle T, busy=1 from T+1. busy lasts 2·BLOCKS_H + M + L + 2 cycles, where M = rows actually moved and L = cnt; done is high in the last of these cycles.
- Each cycle of renderer contention on a port-needing state adds one cycle.

Test Plan:
- Empty board, start, no rnd_req -> no writes; busy high 42 cycles; done pulse; lines_cleared=0; score unchanged at 000.
- Only row 19 full, row 18=10'h001, others 0 -> row 19 rewritten with 10'h001; rows 18..0 end at 0; lines_cleared=1; score 001; busy = 40+19+1+2 = 62 cycles.
- Rows 16..19 full, row 15=10'h3F0, score preloaded to 095 -> row 19=10'h3F0, rows 15..18 zeroed; lines_cleared=4; score 103.
- rnd_req held high for 10 cycles starting in cycle 3 of a pass -> rnd_valid follows one cycle later with the correct row data; the pass completes 10 cycles later than the uncontended run; final board and score identical.
- Score 998, two lines cleared -> score 001. score_clr asserted in the same cycle as SCORE -> score 000.
- reset_n low mid-FILL -> busy=0, done=0, score 000 immediately (asynchronous); a new start then runs a full pass normally.
